cpu_trap_ctrl: RTL and testbench

CPU_TRAP_CTRL -- requirements
Module: cpu_trap_ctrl

---
 rtl/cpu_trap_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cpu_trap_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trap_ctrl.sv
//==============================================================================
// Module   : cpu_trap_ctrl
// Brief    : Machine-mode trap sequencer and CSR-port arbiter. Owns the CSR
//            file read/write ports, shares them with the pipeline's CSR
//            instruction port (csri) while idle, and takes them over to save
//            mepc (and optionally mcause) on a trap, then redirects fetch to
//            mtvec. Also handles mret by redirecting to mepc.
// Config   : `define CPU_TRAP_MCAUSE_EN to add the SAVE_CAUSE state that writes
//            the captured trap cause to mcause before redirecting. When it is
//            undefined, trap_cause is ignored and the trap redirect comes one
//            cycle earlier.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_trap_ctrl (
    input  logic        clk,
    input  logic        rst,

    // Trap and return requests from the pipeline
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_valid,

    // Pipeline CSR-instruction port
    input  logic        csri_valid,
    input  logic [11:0] csri_addr,
    input  logic [31:0] csri_wdata,
    input  logic        csri_wen,
    output logic        csri_ready,
    output logic [31:0] csri_rdata,

    // CSR-file ports (combinational read, clocked write inside the CSR file)
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        csr_wenable,

    // Fetch redirect and status
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [11:0] c_ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC   = 12'h341;
`ifdef CPU_TRAP_MCAUSE_EN
    localparam logic [11:0] c_ADDR_MCAUSE = 12'h342;
`endif

    // Encodings are fixed so both build flavours share the same state values
`ifdef CPU_TRAP_MCAUSE_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAVE_EPC   = 3'd1,
        SAVE_CAUSE = 3'd2,
        REDIRECT   = 3'd3,
        MRET       = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAVE_EPC   = 3'd1,
        REDIRECT   = 3'd3,
        MRET       = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_epc;
    logic        w_trap_accept;

`ifdef CPU_TRAP_MCAUSE_EN
    logic [31:0] r_cause;
`else
    // Cause is not stored in this build; fold it into a sink so it is
    // visibly consumed rather than silently dangling.
    logic        w_unused_cause;
    assign w_unused_cause = ^trap_cause;
`endif

    // Requests are only looked at while idle; anything arriving while busy
    // is dropped rather than queued.
    assign w_trap_accept = (r_state == IDLE) && trap_valid;

    // State register and trap context capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_epc   <= 32'h0;
`ifdef CPU_TRAP_MCAUSE_EN
            r_cause <= 32'h0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_trap_accept) begin
                r_epc   <= trap_pc;
`ifdef CPU_TRAP_MCAUSE_EN
                r_cause <= trap_cause;
`endif
            end
        end
    end

    // Next-state logic and CSR-port arbitration
    always_comb begin
        w_next_state   = r_state;
        csri_ready     = 1'b0;
        csri_rdata     = 32'h0;
        csr_raddr      = 12'h0;
        csr_waddr      = 12'h0;
        csr_wdata      = 32'h0;
        csr_wenable    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        case (r_state)
            IDLE: begin
                // csri only gets the ports when no trap/mret wants them this
                // cycle; the access is a pure pass-through (zero latency).
                csri_ready = ~trap_valid & ~mret_valid;
                if (trap_valid) begin
                    w_next_state = SAVE_EPC;
                end else if (mret_valid) begin
                    w_next_state = MRET;
                end else if (csri_valid) begin
                    csr_raddr   = csri_addr;
                    csri_rdata  = csr_rdata;
                    csr_waddr   = csri_addr;
                    csr_wdata   = csri_wdata;
                    csr_wenable = csri_wen;
                end
            end

            SAVE_EPC: begin
                // Suppressed under reset so an aborted trap leaves mepc alone
                if (!rst) begin
                    csr_waddr   = c_ADDR_MEPC;
                    csr_wdata   = r_epc;
                    csr_wenable = 1'b1;
                end
`ifdef CPU_TRAP_MCAUSE_EN
                w_next_state = SAVE_CAUSE;
`else
                w_next_state = REDIRECT;
`endif
            end

`ifdef CPU_TRAP_MCAUSE_EN
            SAVE_CAUSE: begin
                if (!rst) begin
                    csr_waddr   = c_ADDR_MCAUSE;
                    csr_wdata   = r_cause;
                    csr_wenable = 1'b1;
                end
                w_next_state = REDIRECT;
            end
`endif

            REDIRECT: begin
                // Vectored-mode bits of mtvec are masked off: direct mode only
                csr_raddr = c_ADDR_MTVEC;
                if (!rst) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[31:2], 2'b00};
                end
                w_next_state = IDLE;
            end

            MRET: begin
                csr_raddr = c_ADDR_MEPC;
                if (!rst) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[31:2], 2'b00};
                end
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Busy whenever the sequencer owns the ports
    assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cpu_trap_ctrl.sv
//==============================================================================
// Module   : tb_cpu_trap_ctrl
// Brief    : Directed self-checking bench for cpu_trap_ctrl with a small
//            behavioural CSR file (mtvec, mepc, mcause) on the CSR ports.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_trap_ctrl;

`ifdef CPU_TRAP_MCAUSE_EN
    localparam int TRAP_LEN = 4;   // IDLE, SAVE_EPC, SAVE_CAUSE, REDIRECT
`else
    localparam int TRAP_LEN = 3;   // IDLE, SAVE_EPC, REDIRECT
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_cause = 32'h0;
    logic        mret_valid = 1'b0;
    logic        csri_valid = 1'b0;
    logic [11:0] csri_addr = 12'h0;
    logic [31:0] csri_wdata = 32'h0;
    logic        csri_wen = 1'b0;
    logic        csri_ready;
    logic [31:0] csri_rdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wenable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // CSR file model
    logic [31:0] m_mtvec  = 32'h0;
    logic [31:0] m_mepc   = 32'h0;
    logic [31:0] m_mcause = 32'h0;
    logic        stray_write = 1'b0;
    logic        tb_wr_en = 1'b0;
    logic [11:0] tb_wr_addr = 12'h0;
    logic [31:0] tb_wr_data = 32'h0;

    // Protocol monitor
    logic        prev_rv = 1'b0;
    int          mon_viol = 0;

    cpu_trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .mret_valid     (mret_valid),
        .csri_valid     (csri_valid),
        .csri_addr      (csri_addr),
        .csri_wdata     (csri_wdata),
        .csri_wen       (csri_wen),
        .csri_ready     (csri_ready),
        .csri_rdata     (csri_rdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_wenable    (csr_wenable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // CSR file: combinational read
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_raddr)
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = 32'h0;
        endcase
    end

    // CSR file: clocked write, with a bench-side preload path
    always @(posedge clk) begin
        if (tb_wr_en) begin
            case (tb_wr_addr)
                12'h305: m_mtvec  <= tb_wr_data;
                12'h341: m_mepc   <= tb_wr_data;
                default: m_mcause <= tb_wr_data;
            endcase
        end else if (csr_wenable) begin
            case (csr_waddr)
                12'h305: m_mtvec  <= csr_wdata;
                12'h341: m_mepc   <= csr_wdata;
                12'h342: m_mcause <= csr_wdata;
                default: stray_write <= 1'b1;
            endcase
        end
    end

    // Redirect never back-to-back, redirect_pc zero when not redirecting
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_valid && prev_rv) mon_viol <= mon_viol + 1;
            if (!redirect_valid && redirect_pc != 32'h0) mon_viol <= mon_viol + 1;
        end
        prev_rv <= redirect_valid;
    end

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [11:0] addr, input logic [31:0] data);
        tb_wr_en   = 1'b1;
        tb_wr_addr = addr;
        tb_wr_data = data;
        cyc();
        tb_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %0b/%08h exp 0/00000000", redirect_valid, redirect_pc); end
        checks++; if (csr_wenable !== 1'b0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0) begin errors++; $display("FAIL reset_wport: got %0b/%03h/%08h exp 0/000/00000000", csr_wenable, csr_waddr, csr_wdata); end
        checks++; if (csr_raddr !== 12'h0 || csri_rdata !== 32'h0) begin errors++; $display("FAIL reset_rport: got %03h/%08h exp 000/00000000", csr_raddr, csri_rdata); end
        checks++; if (csri_ready !== 1'b1) begin errors++; $display("FAIL reset_csri_ready: got %0b exp 1", csri_ready); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_trap();
        preload(12'h305, 32'h0000_0103);
        preload(12'h341, 32'h0);
        // Cycle T: request
        trap_valid = 1'b1; trap_pc = 32'h0000_1234; trap_cause = 32'h0000_000B;
        #1;
        checks++; if (busy !== 1'b0 || csri_ready !== 1'b0) begin errors++; $display("FAIL trap_T: busy/ready got %0b/%0b exp 0/0", busy, csri_ready); end
        cyc();
        trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
        // T+1: mepc write
        #1;
        checks++; if (csr_wenable !== 1'b1 || csr_waddr !== 12'h341 || csr_wdata !== 32'h0000_1234) begin errors++; $display("FAIL trap_mepc_write: got %0b/%03h/%08h exp 1/341/00001234", csr_wenable, csr_waddr, csr_wdata); end
        checks++; if (busy !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL trap_T1_status: busy/rv got %0b/%0b exp 1/0", busy, redirect_valid); end
        cyc();
`ifdef CPU_TRAP_MCAUSE_EN
        #1;
        checks++; if (csr_wenable !== 1'b1 || csr_waddr !== 12'h342 || csr_wdata !== 32'h0000_000B) begin errors++; $display("FAIL trap_mcause_write: got %0b/%03h/%08h exp 1/342/0000000b", csr_wenable, csr_waddr, csr_wdata); end
        cyc();
`endif
        // Redirect cycle
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0100) begin errors++; $display("FAIL trap_redirect: got %0b/%08h exp 1/00000100", redirect_valid, redirect_pc); end
        checks++; if (csr_raddr !== 12'h305 || csr_wenable !== 1'b0) begin errors++; $display("FAIL trap_redirect_port: raddr/wen got %03h/%0b exp 305/0", csr_raddr, csr_wenable); end
        cyc();
        #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL trap_return_idle: busy/rv got %0b/%0b exp 0/0", busy, redirect_valid); end
        checks++; if (m_mepc !== 32'h0000_1234) begin errors++; $display("FAIL trap_mepc_value: got %08h exp 00001234", m_mepc); end
`ifdef CPU_TRAP_MCAUSE_EN
        checks++; if (m_mcause !== 32'h0000_000B) begin errors++; $display("FAIL trap_mcause_value: got %08h exp 0000000b", m_mcause); end
`else
        checks++; if (m_mcause !== 32'h0) begin errors++; $display("FAIL trap_mcause_untouched: got %08h exp 00000000", m_mcause); end
`endif
    endtask

    task automatic test_mret();
        preload(12'h341, 32'h0000_2002);
        mret_valid = 1'b1;
        #1;
        checks++; if (csri_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mret_T: ready/busy got %0b/%0b exp 0/0", csri_ready, busy); end
        cyc();
        mret_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_2000) begin errors++; $display("FAIL mret_redirect: busy/rv/pc got %0b/%0b/%08h exp 1/1/00002000", busy, redirect_valid, redirect_pc); end
        checks++; if (csr_raddr !== 12'h341 || csr_wenable !== 1'b0) begin errors++; $display("FAIL mret_port: raddr/wen got %03h/%0b exp 341/0", csr_raddr, csr_wenable); end
        cyc();
        #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL mret_idle: busy/rv got %0b/%0b exp 0/0", busy, redirect_valid); end
    endtask

    task automatic test_csri();
        // Write mtvec through the pipeline port
        csri_valid = 1'b1; csri_addr = 12'h305; csri_wen = 1'b1; csri_wdata = 32'h8000_0000;
        #1;
        checks++; if (csri_ready !== 1'b1 || csr_wenable !== 1'b1 || csr_waddr !== 12'h305 || csr_wdata !== 32'h8000_0000) begin errors++; $display("FAIL csri_write: rdy/wen/waddr/wdata got %0b/%0b/%03h/%08h exp 1/1/305/80000000", csri_ready, csr_wenable, csr_waddr, csr_wdata); end
        checks++; if (csr_raddr !== 12'h305 || csri_rdata !== 32'h0000_0103) begin errors++; $display("FAIL csri_old_read: raddr/rdata got %03h/%08h exp 305/00000103", csr_raddr, csri_rdata); end
        cyc();
        // Read mepc, no write
        csri_addr = 12'h341; csri_wen = 1'b0; csri_wdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (csri_rdata !== 32'h0000_2002 || csr_wenable !== 1'b0) begin errors++; $display("FAIL csri_read: rdata/wen got %08h/%0b exp 00002002/0", csri_rdata, csr_wenable); end
        cyc();
        csri_valid = 1'b0; csri_addr = 12'h0; csri_wdata = 32'h0;
        #1;
        checks++; if (csri_rdata !== 32'h0 || csr_raddr !== 12'h0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0) begin errors++; $display("FAIL csri_idle_zero: got %08h/%03h/%03h/%08h exp all 0", csri_rdata, csr_raddr, csr_waddr, csr_wdata); end
        // Trap now vectors to the new mtvec
        trap_valid = 1'b1; trap_pc = 32'h0000_0040;
        cyc();
        trap_valid = 1'b0;
        for (int k = 1; k < TRAP_LEN - 1; k++) cyc();
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000) begin errors++; $display("FAIL csri_new_mtvec: rv/pc got %0b/%08h exp 1/80000000", redirect_valid, redirect_pc); end
        cyc();
    endtask

    task automatic test_priority();
        preload(12'h341, 32'h0000_2002);
        trap_valid = 1'b1; trap_pc = 32'h0000_0500;
        mret_valid = 1'b1;
        csri_valid = 1'b1; csri_addr = 12'h300; csri_wen = 1'b1; csri_wdata = 32'h0000_0055;
        #1;
        checks++; if (csri_ready !== 1'b0 || csr_wenable !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL prio_T: rdy/wen/rv got %0b/%0b/%0b exp 0/0/0", csri_ready, csr_wenable, redirect_valid); end
        cyc();
        trap_valid = 1'b0; mret_valid = 1'b0; csri_valid = 1'b0; csri_wen = 1'b0;
        #1;
        checks++; if (redirect_valid !== 1'b0 || csr_wenable !== 1'b1 || csr_wdata !== 32'h0000_0500) begin errors++; $display("FAIL prio_trap_taken: rv/wen/wdata got %0b/%0b/%08h exp 0/1/00000500", redirect_valid, csr_wenable, csr_wdata); end
        for (int k = 1; k < TRAP_LEN - 1; k++) cyc();
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000) begin errors++; $display("FAIL prio_redirect: rv/pc got %0b/%08h exp 1/80000000", redirect_valid, redirect_pc); end
        cyc();
        #1;
        checks++; if (stray_write !== 1'b0) begin errors++; $display("FAIL prio_no_csri_write: got %0b exp 0", stray_write); end
        checks++; if (busy !== 1'b0 || m_mepc !== 32'h0000_0500) begin errors++; $display("FAIL prio_end: busy/mepc got %0b/%08h exp 0/00000500", busy, m_mepc); end
    endtask

    task automatic test_back_to_back();
        int epc_writes;
        int rv_count;
        epc_writes = 0;
        rv_count   = 0;
        trap_valid = 1'b1; trap_pc = 32'h0000_0600;
        for (int k = 0; k < 2 * TRAP_LEN; k++) begin
            #1;
            checks++; if (busy !== ((k % TRAP_LEN) != 0)) begin errors++; $display("FAIL b2b_busy[%0d]: got %0b exp %0b", k, busy, ((k % TRAP_LEN) != 0)); end
            if (csr_wenable && csr_waddr == 12'h341) epc_writes++;
            if (redirect_valid) rv_count++;
            cyc();
        end
        trap_valid = 1'b0;
        #1;
        checks++; if (epc_writes != 2 || rv_count != 2) begin errors++; $display("FAIL b2b_counts: epc/redirects got %0d/%0d exp 2/2", epc_writes, rv_count); end
        cyc();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third: busy got %0b exp 0", busy); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        preload(12'h341, 32'h0000_2002);
        trap_valid = 1'b1; trap_pc = 32'h0000_0700;
        cyc();
        trap_valid = 1'b0;
        rst = 1'b1;   // lands on the SAVE_EPC cycle
        #1;
        checks++; if (csr_wenable !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL abort_gate: wen/rv got %0b/%0b exp 0/0", csr_wenable, redirect_valid); end
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || csri_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: busy/rv/rdy got %0b/%0b/%0b exp 0/0/1", busy, redirect_valid, csri_ready); end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (redirect_valid || csr_wenable) pulses++;
            cyc();
            #1;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_quiet: activity got %0d exp 0", pulses); end
        checks++; if (m_mepc !== 32'h0000_2002) begin errors++; $display("FAIL abort_mepc: got %08h exp 00002002", m_mepc); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        test_reset();
        test_trap();
        test_mret();
        test_csri();
        test_priority();
        test_back_to_back();
        test_reset_abort();
        checks++; if (mon_viol != 0) begin errors++; $display("FAIL redirect_protocol: violations got %0d exp 0", mon_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
